// File: rtl/flight_attendant_call_controller_if.sv
// Attendant service port: one presented seat at a time,
// accepted by a single-cycle ack from the galley panel.
interface flight_attendant_call_controller_if #(
   parameter int IDX_W = 3
);
   logic             svc_valid;
   logic [IDX_W-1:0] svc_seat;
   logic             svc_ack;

   modport master (
      output svc_valid,
      output svc_seat,
      input  svc_ack
   );

   modport slave (
      input  svc_valid,
      input  svc_seat,
      output svc_ack
   );
endinterface

// File: rtl/flight_attendant_call_controller.sv
// Multi-seat call lights with round-robin presentation,
// escalation timer and a first-call chime.
module flight_attendant_call_controller #(
   parameter int SEATS      = 8,
   parameter int IDX_W      = 3,
   parameter int ESC_CYCLES = 16,
   parameter int ESC_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEATS-1:0] call,
   input  logic [SEATS-1:0] cancel,
   output logic [SEATS-1:0] light,
   output logic             pending,
   output logic             chime,
   output logic             escalate,
   flight_attendant_call_controller_if.master svc
);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_e;

   localparam logic [ESC_W-1:0] ESC_MAX = ESC_W'(ESC_CYCLES);
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(SEATS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] seat_d;
   logic             valid_d;
   logic [ESC_W-1:0] cnt_q, cnt_d;
   logic             esc_d;
   logic [SEATS-1:0] clr;
   logic [SEATS-1:0] light_d;
   logic             chime_d;
   logic             found;
   logic [IDX_W-1:0] pick;
   logic             wdraw;
   logic [IDX_W-1:0] next_ptr;
   int               idx;

   always_comb begin
      clr = '0;
      for (int i = 0; i < SEATS; i++) begin
         clr[i] = svc.svc_valid & svc.svc_ack &
                  (svc.svc_seat == IDX_W'(i));
      end
      light_d = call | (~cancel & light & ~clr);
      chime_d = (|light_d) & ~pending;
   end

   // first lit seat at or after ptr, wrapping
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < SEATS; k++) begin
         idx = (int'(ptr_q) + k) % SEATS;
         if (!found && light[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      wdraw = light[svc.svc_seat] &
              cancel[svc.svc_seat] &
              ~call[svc.svc_seat];
      next_ptr = (svc.svc_seat == LAST) ? '0
               : svc.svc_seat + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      seat_d  = svc.svc_seat;
      valid_d = svc.svc_valid;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (found) begin
               seat_d  = pick;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (svc.svc_ack || wdraw) begin
               ptr_d   = next_ptr;
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (cnt_q != ESC_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      esc_d = (state_d == PRESENT) && (cnt_d == ESC_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         light         <= '0;
         pending       <= 1'b0;
         chime         <= 1'b0;
         escalate      <= 1'b0;
         svc.svc_valid <= 1'b0;
         svc.svc_seat  <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         light         <= light_d;
         pending       <= |light_d;
         chime         <= chime_d;
         escalate      <= esc_d;
         svc.svc_valid <= valid_d;
         svc.svc_seat  <= seat_d;
      end
   end

endmodule

// File: tb/tb_flight_attendant_call_controller.sv
// Directed bench for the call controller
// (ESC_CYCLES=4 so escalation is quick to reach).
module tb_flight_attendant_call_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] call;
   logic [7:0] cancel;
   logic [7:0] light;
   logic       pending;
   logic       chime;
   logic       escalate;
   int         n_cmp = 0;
   int         n_err = 0;
   int         chimes = 0;

   flight_attendant_call_controller_if #(.IDX_W(3)) svc ();

   flight_attendant_call_controller #(
      .SEATS(8),
      .IDX_W(3),
      .ESC_CYCLES(4),
      .ESC_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .call(call),
      .cancel(cancel),
      .light(light),
      .pending(pending),
      .chime(chime),
      .escalate(escalate),
      .svc(svc.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (chime === 1'b1) chimes++;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      call        = '0;
      cancel      = '0;
      svc.svc_ack = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      call        = 8'hFF;
      cancel      = '0;
      svc.svc_ack = 1'b0;
      step();
      step();
      chk("rst_light", light, 8'h00);
      chk("rst_pend", pending, 1'b0);
      chk("rst_chime", chime, 1'b0);
      chk("rst_valid", svc.svc_valid, 1'b0);
      chk("rst_seat", svc.svc_seat, 3'd0);
      chk("rst_esc", escalate, 1'b0);
      rst_n = 1'b1;
      call  = 8'h00;
      step();
      step();
      chk("idle_light", light, 8'h00);
      chk("idle_valid", svc.svc_valid, 1'b0);

      // single call on seat 5
      chimes = 0;
      call = 8'h20;
      step();
      call = 8'h00;
      chk("one_light", light, 8'h20);
      chk("one_chime", chime, 1'b1);
      chk("one_valid0", svc.svc_valid, 1'b0);
      step();
      chk("one_valid", svc.svc_valid, 1'b1);
      chk("one_seat", svc.svc_seat, 3'd5);
      chk("one_chime0", chime, 1'b0);
      svc.svc_ack = 1'b1;
      step();
      svc.svc_ack = 1'b0;
      chk("one_ack_light", light, 8'h00);
      chk("one_ack_valid", svc.svc_valid, 1'b0);
      chk("one_ack_pend", pending, 1'b0);

      // round robin: seats 0,2,6 then 0,2 from ptr=7
      do_reset();
      chimes = 0;
      call = 8'h45;
      step();
      call = 8'h00;
      step();
      chk("rr_seat_a", svc.svc_seat, 3'd0);
      chk("rr_valid_a", svc.svc_valid, 1'b1);
      svc.svc_ack = 1'b1;
      step();
      svc.svc_ack = 1'b0;
      chk("rr_light_a", light, 8'h44);
      chk("rr_bubble_a", svc.svc_valid, 1'b0);
      step();
      chk("rr_seat_b", svc.svc_seat, 3'd2);
      svc.svc_ack = 1'b1;
      step();
      svc.svc_ack = 1'b0;
      step();
      chk("rr_seat_c", svc.svc_seat, 3'd6);
      svc.svc_ack = 1'b1;
      step();
      svc.svc_ack = 1'b0;
      chk("rr_empty", light, 8'h00);
      chk("rr_chimes1", chimes, 1);
      call = 8'h05;
      step();
      call = 8'h00;
      step();
      chk("rr_wrap_seat", svc.svc_seat, 3'd0);
      svc.svc_ack = 1'b1;
      step();
      svc.svc_ack = 1'b0;
      step();
      chk("rr_wrap_seat2", svc.svc_seat, 3'd2);
      svc.svc_ack = 1'b1;
      step();
      svc.svc_ack = 1'b0;
      chk("rr_chimes2", chimes, 2);

      // escalation on seat 3
      do_reset();
      call = 8'h08;
      step();
      call = 8'h00;
      step();
      chk("esc_valid", svc.svc_valid, 1'b1);
      chk("esc_at0", escalate, 1'b0);
      step();
      step();
      step();
      chk("esc_at3", escalate, 1'b0);
      step();
      chk("esc_at4", escalate, 1'b1);
      step();
      chk("esc_hold", escalate, 1'b1);
      svc.svc_ack = 1'b1;
      step();
      svc.svc_ack = 1'b0;
      chk("esc_drop", escalate, 1'b0);
      chk("esc_vdrop", svc.svc_valid, 1'b0);

      // call and cancel together on seat 1
      do_reset();
      call   = 8'h02;
      cancel = 8'h02;
      step();
      call   = 8'h00;
      cancel = 8'h00;
      chk("cc_light", light, 8'h02);

      // withdrawal of presented seat 4, seat 5 waiting
      do_reset();
      call = 8'h30;
      step();
      call = 8'h00;
      step();
      chk("wd_seat4", svc.svc_seat, 3'd4);
      cancel = 8'h10;
      step();
      cancel = 8'h00;
      chk("wd_valid0", svc.svc_valid, 1'b0);
      chk("wd_light", light, 8'h20);
      step();
      chk("wd_valid1", svc.svc_valid, 1'b1);
      chk("wd_seat5", svc.svc_seat, 3'd5);

      // ack plus call on the presented seat
      svc.svc_ack = 1'b1;
      call = 8'h20;
      step();
      svc.svc_ack = 1'b0;
      call = 8'h00;
      chk("ac_light", light, 8'h20);
      chk("ac_valid0", svc.svc_valid, 1'b0);
      step();
      chk("ac_valid1", svc.svc_valid, 1'b1);
      chk("ac_seat", svc.svc_seat, 3'd5);

      // mid-operation reset with seat 4 escalated
      do_reset();
      call = 8'hFF;
      step();
      call = 8'h00;
      step();
      for (int s = 0; s < 4; s++) begin
         svc.svc_ack = 1'b1;
         call = 8'(1 << s);
         step();
         svc.svc_ack = 1'b0;
         call = 8'h00;
         step();
      end
      chk("mr_seat4", svc.svc_seat, 3'd4);
      chk("mr_all", light, 8'hFF);
      for (int c = 0; c < 4; c++) step();
      chk("mr_esc", escalate, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mr_light", light, 8'h00);
      chk("mr_pend", pending, 1'b0);
      chk("mr_valid", svc.svc_valid, 1'b0);
      chk("mr_seat", svc.svc_seat, 3'd0);
      chk("mr_escz", escalate, 1'b0);
      call = 8'h11;
      step();
      call = 8'h00;
      step();
      chk("mr_ptr0", svc.svc_seat, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
